// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file with write counter.
package regfile_pkg;

  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned REG_IDX_W        = 5;
  localparam int unsigned ZERO_REG_DEFAULT = 31;
  localparam int unsigned COUNT_W          = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wr_decoder.sv
// 5:32 one-hot write-enable decode; all-zero whenever the write enable is low.
module regfile_wr_decoder
  import regfile_pkg::*;
(
  input  logic                i_we,
  input  reg_idx_t            i_idx,
  output logic [NUM_REGS-1:0] o_en
);

  // Compare form keeps X on i_idx from leaking through when i_we is low.
  always_comb begin
    o_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_en[i] = i_we && (i_idx == REG_IDX_W'(i));
    end
  end

endmodule

// File: rtl/regfile_wr.sv
// Register file: 32 x DATA_W, two combinational read ports, hardwired-zero register,
// 16-bit committed-write counter. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_wr
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RegWrite,
  input  reg_idx_t           WriteRegister,
  input  logic [DATA_W-1:0]  WriteData,
  input  reg_idx_t           ReadRegister1,
  input  reg_idx_t           ReadRegister2,
  output logic [DATA_W-1:0]  ReadData1,
  output logic [DATA_W-1:0]  ReadData2,
  output logic [COUNT_W-1:0] WriteCount
);

  localparam reg_idx_t ZERO_IDX = REG_IDX_W'(ZERO_REG);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [COUNT_W-1:0]  r_write_count;
  logic [NUM_REGS-1:0] w_en;
  logic                w_commit;

  regfile_wr_decoder u_decoder (
    .i_we  (RegWrite),
    .i_idx (WriteRegister),
    .o_en  (w_en)
  );

  assign w_commit = RegWrite && (WriteRegister != ZERO_IDX);

  // Storage and counter; reset wins over any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_write_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_en[i] && (REG_IDX_W'(i) != ZERO_IDX)) begin
          r_regs[i] <= WriteData;
        end
      end
      if (w_commit) begin
        r_write_count <= r_write_count + COUNT_W'(1);
      end
    end
  end

  // Read muxes; the zero register is forced to 0 regardless of storage contents.
  always_comb begin
    ReadData1 = (ReadRegister1 == ZERO_IDX) ? '0 : r_regs[ReadRegister1];
    ReadData2 = (ReadRegister2 == ZERO_IDX) ? '0 : r_regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (w_commit && !reset && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
    if (w_commit && !reset && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
`endif
  end

  assign WriteCount = r_write_count;

endmodule
